cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Arbitrates the single shared multi-cycle memory port between the I-cache and the D-cache. It sits directly downstream of both cache instances: it takes each cache's memory request (fill reads driven by the cache fill FSM, write-through writes from the pipeline), and grants the memory to one cache at a time. It tracks every in-flight read so each returned word's data-valid pulse reaches only the cache that issued it.

## Interface
Parameters:
- LATENCY, 4, memory read latency in cycles from enable to data-valid; also the depth of the read-tag pipe.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- i_req  in  1  I-cache wants memory (its CacheBusy | MemWrite).
- i_wr  in  1  I-cache request is a write (always 0 in practice; honoured anyway).
- i_addr  in  16  I-cache memory address.
- i_wdata  in  16  I-cache write data.
- d_req, d_wr, d_addr, d_wdata  in  1/1/16/16  same, for the D-cache.
- i_gnt, d_gnt  out  1  registered grant; at most one high.
- i_valid, d_valid  out  1  routed memory data-valid.
- rdata  out  16  memory read data, broadcast to both caches; qualify with *_valid.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_valid  in  1  memory data-valid.
- mem_rdata  in  16  memory read data.
- protocol_err  out  1  sticky: mem_valid arrived with no matching tag.

## Operation
- States: IDLE, GRANT_I, GRANT_D. i_gnt = (state==GRANT_I), d_gnt = (state==GRANT_D).
- last register (I or D) records the most recently granted client; reset value I, so D wins the first contention.
- IDLE: only d_req -> GRANT_D; only i_req -> GRANT_I; both -> the client != last; neither -> stay.
- GRANT_X: the grant is held while x_req = 1, so a full 8-word fill is never interleaved. When x_req = 0, the other client's req decides the next state. If it is 1, go directly to GRANT_other (handoff). If it is 0, go to IDLE. last <= X on the exit.
- Memory drive, combinational from the owner: mem_enable = owner_req & gnt, mem_wr = owner_wr & mem_enable, mem_addr = owner_addr, mem_wdata = owner_wdata. In IDLE, all mem_* outputs are 0.
- Tag pipe: a LATENCY-stage shift register of {valid, id}. Each cycle, stage 0 <= {mem_enable & ~mem_wr, owner id}.
- Routing: i_valid = mem_valid & tag_out.valid & (tag_out.id==I). d_valid is the same with id==D.
- Routing uses the tag, not the current grant. Reads issued before a handoff still return to their issuer.
- mem_valid with tag_out.valid = 0 is dropped (no *_valid) and sets protocol_err. Only rst clears protocol_err.
- Writes are single-cycle and occupy no tag slot.

## Timing
- Reset values: state IDLE, last I, tag pipe all-invalid, protocol_err 0; i_gnt, d_gnt, all mem_* and *_valid 0.
- Grant latency: a req rising at cycle t from IDLE gives gnt=1 at t+1, with mem_enable at t+1.
- Read issued at cycle t gives the routed *_valid at t+LATENCY, in the same cycle as mem_valid.
- Release: owner req falling at t gives the owner's gnt=0 at t+1. The other's gnt is 1 at t+1 if its req was 1 at t.
- Simultaneous first requests in IDLE: d_req and i_req both rising at t gives d_gnt at t+1 (after reset). Afterwards they alternate per last.
- A request arriving while the other client owns the grant waits: its gnt stays 0 and the requesting cache stays stalled.
- Reset mid-fill: all state clears the next edge, and outstanding tags are discarded. A stray mem_valid afterwards is dropped and sets protocol_err.

## Test plan
- D-cache fill alone: d_req held 8 cycles with addresses 0x1000..0x100E, step 2 -> d_gnt from cycle 1; 8 d_valid pulses at cycles 5..12 carrying matching rdata; i_valid never set.
- Contention from reset: i_req and d_req rise together -> D granted first. When d_req drops, i_gnt = 1 the next cycle. Each gets 8 valids, with no cross-routing at the handoff boundary.
- Alternation: both requesting repeatedly over 4 grant periods -> order D, I, D, I.
- Write-through: d_req=1, d_wr=1, d_addr=0x2002, d_wdata=0xBEEF for one cycle -> mem_wr=1 with 0x2002/0xBEEF exactly one cycle; no tag enters the pipe and no valid is returned.
- Reset mid-fill: assert rst during the 3rd word of an I-fill -> next cycle all grants and mem_* are 0. An injected mem_valid is dropped and protocol_err = 1.
- LATENCY=2 build: a read at t gives d_valid at t+2.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Grants the shared multi-cycle memory port to the I-cache or the
//            D-cache. A read-tag pipe routes each returned word's data-valid
//            pulse back to the cache that issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic        i_valid,
    output logic        d_valid,
    output logic [15:0] rdata,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic        protocol_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANT_I = 2'd1;
    localparam logic [1:0] c_GRANT_D = 2'd2;

    localparam logic c_ID_I = 1'b0;
    localparam logic c_ID_D = 1'b1;

    localparam int c_TOP = LATENCY - 1;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_last;
    logic               w_last_nxt;

    logic               w_owner_req;
    logic               w_owner_wr;
    logic               w_owner_id;
    logic [15:0]        w_owner_addr;
    logic [15:0]        w_owner_wdata;
    logic               w_gnt_any;
    logic               w_issue_rd;

    logic [LATENCY-1:0] r_tag_v;
    logic [LATENCY-1:0] r_tag_id;
    logic               w_tag_out_v;
    logic               w_tag_out_id;

    logic               r_protocol_err;

    // State and last-owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_last  <= c_ID_I;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state: hold the grant while the owner keeps requesting, hand off
    // directly when the other side is waiting, round-robin on contention.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            c_IDLE: begin
                if (i_req && d_req) begin
                    w_state_nxt = (r_last == c_ID_I) ? c_GRANT_D : c_GRANT_I;
                end else if (d_req) begin
                    w_state_nxt = c_GRANT_D;
                end else if (i_req) begin
                    w_state_nxt = c_GRANT_I;
                end
            end
            c_GRANT_I: begin
                if (!i_req) begin
                    w_last_nxt  = c_ID_I;
                    w_state_nxt = d_req ? c_GRANT_D : c_IDLE;
                end
            end
            c_GRANT_D: begin
                if (!d_req) begin
                    w_last_nxt  = c_ID_D;
                    w_state_nxt = i_req ? c_GRANT_I : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Owner mux: selects the granted client's request; everything is zero
    // when nobody holds the grant.
    always_comb begin
        w_owner_req   = 1'b0;
        w_owner_wr    = 1'b0;
        w_owner_id    = c_ID_I;
        w_owner_addr  = 16'h0000;
        w_owner_wdata = 16'h0000;
        w_gnt_any     = 1'b0;
        case (r_state)
            c_GRANT_I: begin
                w_owner_req   = i_req;
                w_owner_wr    = i_wr;
                w_owner_id    = c_ID_I;
                w_owner_addr  = i_addr;
                w_owner_wdata = i_wdata;
                w_gnt_any     = 1'b1;
            end
            c_GRANT_D: begin
                w_owner_req   = d_req;
                w_owner_wr    = d_wr;
                w_owner_id    = c_ID_D;
                w_owner_addr  = d_addr;
                w_owner_wdata = d_wdata;
                w_gnt_any     = 1'b1;
            end
            default: begin
                w_gnt_any     = 1'b0;
            end
        endcase
    end

    assign i_gnt      = (r_state == c_GRANT_I);
    assign d_gnt      = (r_state == c_GRANT_D);
    assign mem_enable = w_owner_req & w_gnt_any;
    assign mem_wr     = w_owner_wr & mem_enable;
    assign mem_addr   = w_owner_addr;
    assign mem_wdata  = w_owner_wdata;
    assign w_issue_rd = mem_enable & ~mem_wr;

    // Read-tag pipe: one slot per cycle of memory latency. Writes never
    // produce a return, so they enter as invalid slots.
    generate
        if (LATENCY > 1) begin : g_tag_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_v  <= '0;
                    r_tag_id <= '0;
                end else begin
                    r_tag_v  <= {r_tag_v[LATENCY-2:0], w_issue_rd};
                    r_tag_id <= {r_tag_id[LATENCY-2:0], w_owner_id};
                end
            end
        end else begin : g_tag_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_v  <= '0;
                    r_tag_id <= '0;
                end else begin
                    r_tag_v  <= w_issue_rd;
                    r_tag_id <= w_owner_id;
                end
            end
        end
    endgenerate

    assign w_tag_out_v  = r_tag_v[c_TOP];
    assign w_tag_out_id = r_tag_id[c_TOP];

    // Route data-valid by the tag of the read that produced it, not by the
    // current grant, so reads issued before a handoff reach their issuer.
    assign i_valid = mem_valid & w_tag_out_v & (w_tag_out_id == c_ID_I);
    assign d_valid = mem_valid & w_tag_out_v & (w_tag_out_id == c_ID_D);
    assign rdata   = mem_rdata;

    // Sticky error for a data-valid that no outstanding read accounts for.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_protocol_err <= 1'b0;
        end else if (mem_valid && !w_tag_out_v) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire
